// File: rtl/store_buffer_pkg.sv
// Shared sizing constants, pointer type and entry layout for the store buffer.
// Pointers carry one extra wrap bit above the entry index.
package store_buffer_pkg;
   localparam int SB_NUM   = 8;
   localparam int SB_SEL   = 3;
   localparam int ADDR_LEN = 32;
   localparam int DATA_LEN = 32;
   localparam int MASK_LEN = DATA_LEN / 8;
   localparam int PTR_W    = SB_SEL + 1;

   typedef logic [PTR_W-1:0] sb_ptr_t;

   typedef struct packed {
      logic [ADDR_LEN-1:0] addr;
      logic [DATA_LEN-1:0] data;
      logic [MASK_LEN-1:0] mask;
   } sb_entry_t;

   // Entries between two pointers; the wrap bit makes plain subtraction exact.
   function automatic sb_ptr_t ptr_dist(input sb_ptr_t head, input sb_ptr_t tail);
      return sb_ptr_t'(tail - head);
   endfunction
endpackage

// File: rtl/store_buffer_if.sv
// Drain port between the store buffer (master) and data memory (slave).
interface store_buffer_if;
   import store_buffer_pkg::*;

   logic                mem_req_o;
   logic [ADDR_LEN-1:0] mem_addr_o;
   logic [DATA_LEN-1:0] mem_data_o;
   logic [MASK_LEN-1:0] mem_mask_o;
   logic                mem_ack_i;

   modport master (output mem_req_o, mem_addr_o, mem_data_o, mem_mask_o, input mem_ack_i);
   modport slave  (input mem_req_o, mem_addr_o, mem_data_o, mem_mask_o, output mem_ack_i);
endinterface

// File: rtl/store_buffer_chk.sv
// Simulation checker: the reorder buffer must never retire more stores than are speculative.
module store_buffer_chk
   import store_buffer_pkg::*;
(
   input logic       clk_i,
   input logic       reset_i,
   input logic [1:0] commit_num_i,
   input sb_ptr_t    spec_cnt_i
);
   a_commit_in_range: assert property (@(posedge clk_i) disable iff (!reset_i)
      PTR_W'(commit_num_i) <= spec_cnt_i);
endmodule

// File: rtl/store_buffer_fwd_search.sv
// Youngest-first priority search over the occupied entries, walking back from the tail.
module sb_fwd_search
   import store_buffer_pkg::*;
(
   input  logic [SB_NUM-1:0] match_i,
   input  sb_ptr_t           alloc_ptr_i,
   input  sb_ptr_t           count_i,
   output logic              hit_o,
   output logic [SB_SEL-1:0] idx_o
);
   logic [SB_SEL-1:0] slot_s;
   logic              take_s;

   // Oldest candidate is visited first so the youngest match overwrites it last.
   always_comb begin
      hit_o  = 1'b0;
      idx_o  = '0;
      slot_s = '0;
      take_s = 1'b0;
      for (int i = SB_NUM - 1; i >= 0; i--) begin
         slot_s = alloc_ptr_i[SB_SEL-1:0] - SB_SEL'(i + 1);
         take_s = (PTR_W'(i) < count_i) && match_i[slot_s];
         hit_o  = take_s ? 1'b1 : hit_o;
         idx_o  = take_s ? slot_s : idx_o;
      end
   end
endmodule

// File: rtl/store_buffer.sv
// Program-ordered store buffer: speculative hold, ROB commit, flush on mispredict,
// in-order drain to memory and youngest-match load forwarding.
module store_buffer
   import store_buffer_pkg::*;
(
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                alloc_valid_i,
   input  logic [ADDR_LEN-1:0] alloc_addr_i,
   input  logic [DATA_LEN-1:0] alloc_data_i,
   input  logic [MASK_LEN-1:0] alloc_mask_i,
   output logic                alloc_ready_o,
   input  logic [1:0]          store_commit_num_i,
   input  logic                prmiss_i,
   store_buffer_if.master      mem_if,
   input  logic [ADDR_LEN-1:0] ld_addr_i,
   output logic                ld_hit_o,
   output logic [DATA_LEN-1:0] ld_data_o,
   output logic [MASK_LEN-1:0] ld_mask_o,
   output logic [SB_SEL:0]     count_o,
   output logic                empty_o
);
   sb_ptr_t           ret_ptr_q, com_ptr_q, alloc_ptr_q;
   sb_ptr_t           ret_ptr_d, com_ptr_d, alloc_ptr_d;
   sb_entry_t         entry_q [SB_NUM];
   sb_ptr_t           count_s, spec_cnt_s, commit_amt_s, commit_req_s;
   logic              full_s, do_alloc_s, do_drain_s, fwd_hit_s;
   logic [SB_SEL-1:0] fwd_idx_s;
   logic [SB_NUM-1:0] match_s;

   assign count_s      = ptr_dist(ret_ptr_q, alloc_ptr_q);
   assign spec_cnt_s   = ptr_dist(com_ptr_q, alloc_ptr_q);
   assign full_s       = (alloc_ptr_q[SB_SEL-1:0] == ret_ptr_q[SB_SEL-1:0]) &&
                         (alloc_ptr_q[SB_SEL] != ret_ptr_q[SB_SEL]);
   assign commit_req_s = PTR_W'(store_commit_num_i);
   assign commit_amt_s = (commit_req_s > spec_cnt_s) ? spec_cnt_s : commit_req_s;
   assign do_alloc_s   = alloc_valid_i & ~full_s & ~prmiss_i;
   assign do_drain_s   = mem_if.mem_req_o & mem_if.mem_ack_i;

   assign alloc_ready_o = ~full_s;
   assign count_o       = count_s;
   assign empty_o       = (count_s == '0);

   assign mem_if.mem_req_o  = (ret_ptr_q != com_ptr_q);
   assign mem_if.mem_addr_o = entry_q[ret_ptr_q[SB_SEL-1:0]].addr;
   assign mem_if.mem_data_o = entry_q[ret_ptr_q[SB_SEL-1:0]].data;
   assign mem_if.mem_mask_o = entry_q[ret_ptr_q[SB_SEL-1:0]].mask;

   // Pointer next-state; a flush rewinds the tail to the post-commit boundary.
   always_comb begin
      ret_ptr_d   = ret_ptr_q + PTR_W'(do_drain_s);
      com_ptr_d   = com_ptr_q + commit_amt_s;
      alloc_ptr_d = alloc_ptr_q;
      if (prmiss_i) begin
         alloc_ptr_d = com_ptr_d;
      end else if (do_alloc_s) begin
         alloc_ptr_d = alloc_ptr_q + PTR_W'(1);
      end else begin
         alloc_ptr_d = alloc_ptr_q;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         ret_ptr_q   <= '0;
         com_ptr_q   <= '0;
         alloc_ptr_q <= '0;
      end else begin
         ret_ptr_q   <= ret_ptr_d;
         com_ptr_q   <= com_ptr_d;
         alloc_ptr_q <= alloc_ptr_d;
      end
   end

   // Entry storage keeps its contents across reset; occupancy comes from the pointers.
   always_ff @(posedge clk_i) begin
      if (do_alloc_s) begin
         entry_q[alloc_ptr_q[SB_SEL-1:0]] <= '{addr: alloc_addr_i, data: alloc_data_i, mask: alloc_mask_i};
      end
   end

   // Word-granular address compare for every slot.
   always_comb begin
      match_s = '0;
      for (int j = 0; j < SB_NUM; j++) begin
         match_s[j] = (entry_q[j].addr[ADDR_LEN-1:2] == ld_addr_i[ADDR_LEN-1:2]);
      end
   end

   sb_fwd_search u_fwd (
      .match_i     (match_s),
      .alloc_ptr_i (alloc_ptr_q),
      .count_i     (count_s),
      .hit_o       (fwd_hit_s),
      .idx_o       (fwd_idx_s)
   );

   assign ld_hit_o  = fwd_hit_s;
   assign ld_data_o = fwd_hit_s ? entry_q[fwd_idx_s].data : '0;
   assign ld_mask_o = fwd_hit_s ? entry_q[fwd_idx_s].mask : '0;

   store_buffer_chk u_chk (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .commit_num_i (store_commit_num_i),
      .spec_cnt_i   (spec_cnt_s)
   );
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench: drained stores are checked by a scoreboard monitor, state by direct checks.
module tb_store_buffer;
   import store_buffer_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        alloc_valid_i = 1'b0;
   logic [31:0] alloc_addr_i = 32'h0;
   logic [31:0] alloc_data_i = 32'h0;
   logic [3:0]  alloc_mask_i = 4'h0;
   logic        alloc_ready_o;
   logic [1:0]  store_commit_num_i = 2'd0;
   logic        prmiss_i = 1'b0;
   logic [31:0] ld_addr_i = 32'h0;
   logic        ld_hit_o;
   logic [31:0] ld_data_o;
   logic [3:0]  ld_mask_o;
   logic [3:0]  count_o;
   logic        empty_o;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   store_buffer_if mem_if ();

   store_buffer dut (
      .clk_i              (clk_i),
      .reset_i            (reset_i),
      .alloc_valid_i      (alloc_valid_i),
      .alloc_addr_i       (alloc_addr_i),
      .alloc_data_i       (alloc_data_i),
      .alloc_mask_i       (alloc_mask_i),
      .alloc_ready_o      (alloc_ready_o),
      .store_commit_num_i (store_commit_num_i),
      .prmiss_i           (prmiss_i),
      .mem_if             (mem_if),
      .ld_addr_i          (ld_addr_i),
      .ld_hit_o           (ld_hit_o),
      .ld_data_o          (ld_data_o),
      .ld_mask_o          (ld_mask_o),
      .count_o            (count_o),
      .empty_o            (empty_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic alloc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      alloc_valid_i = 1'b1;
      alloc_addr_i  = a;
      alloc_data_i  = d;
      alloc_mask_i  = m;
      tick();
      alloc_valid_i = 1'b0;
   endtask

   task automatic lookup(input string name, input logic [31:0] a, input logic hit,
                         input logic [31:0] d, input logic [3:0] m);
      ld_addr_i = a;
      #1;
      check({name, "_hit"}, {31'd0, ld_hit_o}, {31'd0, hit});
      check({name, "_data"}, ld_data_o, d);
      check({name, "_mask"}, {28'd0, ld_mask_o}, {28'd0, m});
   endtask

   // Scoreboard monitor: every accepted drain must match the oldest expected store.
   always @(negedge clk_i) begin
      if (reset_i && mem_if.mem_req_o && mem_if.mem_ack_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL drain_unexpected: got addr 0x%0h, expected no drain", mem_if.mem_addr_o);
         end else begin
            mon_e = exp_q.pop_front();
            check("drain_addr", mem_if.mem_addr_o, mon_e.addr);
            check("drain_data", mem_if.mem_data_o, mon_e.data);
            check("drain_mask", {28'd0, mem_if.mem_mask_o}, {28'd0, mon_e.mask});
         end
      end
   end

   initial begin
      mem_if.mem_ack_i = 1'b0;
      #12;
      check("rst_count", {28'd0, count_o}, 32'd0);
      check("rst_empty", {31'd0, empty_o}, 32'd1);
      check("rst_ready", {31'd0, alloc_ready_o}, 32'd1);
      check("rst_req", {31'd0, mem_if.mem_req_o}, 32'd0);
      check("rst_hit", {31'd0, ld_hit_o}, 32'd0);
      tick();
      reset_i = 1'b1;
      tick();

      // Three speculative stores, youngest 0x100 wins the forward
      alloc(32'h100, 32'hA, 4'hF);
      alloc(32'h104, 32'hB, 4'hF);
      alloc(32'h100, 32'hC, 4'hF);
      check("t1_count", {28'd0, count_o}, 32'd3);
      check("t1_req", {31'd0, mem_if.mem_req_o}, 32'd0);
      lookup("t1_ld102", 32'h102, 1'b1, 32'hC, 4'hF);
      lookup("t1_ld104", 32'h104, 1'b1, 32'hB, 4'hF);
      lookup("t1_ld200", 32'h200, 1'b0, 32'h0, 4'h0);

      // Commit two, drain back-to-back
      exp_q.push_back('{32'h100, 32'hA, 4'hF});
      exp_q.push_back('{32'h104, 32'hB, 4'hF});
      store_commit_num_i = 2'd2;
      tick();
      store_commit_num_i = 2'd0;
      check("t2_req", {31'd0, mem_if.mem_req_o}, 32'd1);
      mem_if.mem_ack_i = 1'b1;
      tick();
      tick();
      mem_if.mem_ack_i = 1'b0;
      check("t2_count", {28'd0, count_o}, 32'd1);
      check("t2_req_drop", {31'd0, mem_if.mem_req_o}, 32'd0);

      // Fill to 8, drop a 9th, free one slot by draining
      for (int i = 0; i < 7; i++) alloc(32'h200 + 32'(4 * i), 32'h10 + 32'(i), 4'hF);
      check("t3_count_full", {28'd0, count_o}, 32'd8);
      check("t3_ready_full", {31'd0, alloc_ready_o}, 32'd0);
      alloc(32'h300, 32'hFF, 4'hF);
      check("t3_count_drop", {28'd0, count_o}, 32'd8);
      lookup("t3_ld300", 32'h300, 1'b0, 32'h0, 4'h0);
      lookup("t3_ld20c", 32'h20C, 1'b1, 32'h13, 4'hF);
      exp_q.push_back('{32'h100, 32'hC, 4'hF});
      store_commit_num_i = 2'd1;
      tick();
      store_commit_num_i = 2'd0;
      mem_if.mem_ack_i = 1'b1;
      tick();
      mem_if.mem_ack_i = 1'b0;
      check("t3_ready_after", {31'd0, alloc_ready_o}, 32'd1);
      check("t3_count_after", {28'd0, count_o}, 32'd7);
      lookup("t3_ld100_gone", 32'h100, 1'b0, 32'h0, 4'h0);

      // Flush everything, then commit one of four speculative with a mispredict
      prmiss_i = 1'b1;
      tick();
      prmiss_i = 1'b0;
      check("t4_flush_count", {28'd0, count_o}, 32'd0);
      check("t4_flush_empty", {31'd0, empty_o}, 32'd1);
      alloc(32'h400, 32'h20, 4'h3);
      for (int i = 1; i < 4; i++) alloc(32'h400 + 32'(4 * i), 32'h20 + 32'(i), 4'hF);
      check("t4_count4", {28'd0, count_o}, 32'd4);
      store_commit_num_i = 2'd1;
      prmiss_i = 1'b1;
      exp_q.push_back('{32'h400, 32'h20, 4'h3});
      tick();
      store_commit_num_i = 2'd0;
      prmiss_i = 1'b0;
      check("t4_count1", {28'd0, count_o}, 32'd1);
      check("t4_req", {31'd0, mem_if.mem_req_o}, 32'd1);
      lookup("t4_ld404_flushed", 32'h404, 1'b0, 32'h0, 4'h0);

      // Stall the ack: head outputs must hold
      for (int i = 0; i < 5; i++) begin
         check("t5_stall_req", {31'd0, mem_if.mem_req_o}, 32'd1);
         check("t5_stall_addr", mem_if.mem_addr_o, 32'h400);
         check("t5_stall_data", mem_if.mem_data_o, 32'h20);
         check("t5_stall_mask", {28'd0, mem_if.mem_mask_o}, 32'h3);
         tick();
      end
      mem_if.mem_ack_i = 1'b1;
      tick();
      mem_if.mem_ack_i = 1'b0;
      check("t5_count0", {28'd0, count_o}, 32'd0);

      // 20 allocate/commit/drain rounds wrap the pointers
      for (int r = 0; r < 20; r++) begin
         alloc(32'h1000 + 32'(4 * r), 32'h100 + 32'(r), 4'(r + 1));
         lookup("t6_fwd", 32'h1000 + 32'(4 * r), 1'b1, 32'h100 + 32'(r), 4'(r + 1));
         exp_q.push_back('{32'h1000 + 32'(4 * r), 32'h100 + 32'(r), 4'(r + 1)});
         store_commit_num_i = 2'd1;
         tick();
         store_commit_num_i = 2'd0;
         mem_if.mem_ack_i = 1'b1;
         tick();
         mem_if.mem_ack_i = 1'b0;
      end
      check("t6_count", {28'd0, count_o}, 32'd0);
      check("t6_empty", {31'd0, empty_o}, 32'd1);
      check("t6_ready", {31'd0, alloc_ready_o}, 32'd1);

      // Asynchronous reset in the middle of a drain
      alloc(32'h500, 32'h30, 4'hF);
      alloc(32'h504, 32'h31, 4'hF);
      exp_q.push_back('{32'h500, 32'h30, 4'hF});
      store_commit_num_i = 2'd2;
      tick();
      store_commit_num_i = 2'd0;
      mem_if.mem_ack_i = 1'b1;
      tick();
      #2;
      reset_i = 1'b0;
      #1;
      check("t7_req", {31'd0, mem_if.mem_req_o}, 32'd0);
      check("t7_count", {28'd0, count_o}, 32'd0);
      check("t7_empty", {31'd0, empty_o}, 32'd1);
      mem_if.mem_ack_i = 1'b0;
      tick();
      reset_i = 1'b1;
      tick();

      check("sb_leftover", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
